// File: rtl/accesscode_corr.sv
// Access-code correlator: slides a 64-bit window over rxbit, flags a sync hit,
// then checks the 4-bit alternating trailer that follows the sync word.
module accesscode_corr (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        p_1us,
  input  logic        rxbit,
  input  logic        corr_en,
  input  logic [1:0]  sync_sel,
  input  logic [63:0] regi_syncword_CAC,
  input  logic [63:0] regi_syncword_DAC,
  input  logic [63:0] regi_syncword_GIAC,
  input  logic [63:0] regi_syncword_DIAC,
  input  logic [6:0]  regi_corr_th,
  input  logic [9:0]  regi_search_win,
  output logic        rx_trailer_st_p,
  output logic        rxCAC,
  output logic        sync_miss_p,
  output logic        trailer_done_p,
  output logic        trailer_ok,
  output logic [6:0]  corr_matches
);

  typedef enum logic [1:0] {
    IDLE, SEARCH, TRAILER, DONE
  } state_t;

  state_t      state, state_n;
  logic        en_d, p_d;
  logic [63:0] sr, word, diff;
  logic [6:0]  fill, match;
  logic [9:0]  wcnt;
  logic [2:0]  tcnt;
  logic        terr, exp_b;
  logic        start, hit, miss, tdone;

  always_comb begin
    word = regi_syncword_CAC;
    unique case (sync_sel)
      2'd0: word = regi_syncword_CAC;
      2'd1: word = regi_syncword_DAC;
      2'd2: word = regi_syncword_GIAC;
      2'd3: word = regi_syncword_DIAC;
    endcase
  end

  assign diff = sr ^ word;

  always_comb begin
    match = '0;
    for (int i = 0; i < 64; i++)
      match = match + {6'd0, ~diff[i]};
  end

  // Trailer alternates, starting with the inverse of the sync MSB
  assign exp_b = ~word[63] ^ tcnt[0];

  always_comb begin
    state_n = state;
    start   = 1'b0;
    hit     = 1'b0;
    miss    = 1'b0;
    tdone   = 1'b0;
    if (!corr_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (!en_d) begin
          start   = 1'b1;
          state_n = SEARCH;
        end
        SEARCH: if (p_d) begin
          if (fill == 7'd64 && match >= regi_corr_th) begin
            hit     = 1'b1;
            state_n = TRAILER;
          end else if (regi_search_win != '0 &&
                       wcnt == regi_search_win) begin
            miss    = 1'b1;
            state_n = DONE;
          end
        end
        TRAILER: if (tcnt == 3'd4) begin
          tdone   = 1'b1;
          state_n = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      en_d            <= 1'b0;
      p_d             <= 1'b0;
      sr              <= '0;
      fill            <= '0;
      wcnt            <= '0;
      tcnt            <= '0;
      terr            <= 1'b0;
      rx_trailer_st_p <= 1'b0;
      sync_miss_p     <= 1'b0;
      trailer_done_p  <= 1'b0;
      rxCAC           <= 1'b0;
      trailer_ok      <= 1'b0;
      corr_matches    <= '0;
    end else begin
      en_d            <= corr_en;
      p_d             <= p_1us;
      rx_trailer_st_p <= hit;
      sync_miss_p     <= miss;
      trailer_done_p  <= tdone;
      if (start) begin
        sr           <= '0;
        fill         <= '0;
        wcnt         <= '0;
        tcnt         <= '0;
        terr         <= 1'b0;
        rxCAC        <= 1'b0;
        trailer_ok   <= 1'b0;
        corr_matches <= '0;
      end
      if (p_1us && (state == SEARCH || state == TRAILER))
        sr <= {rxbit, sr[63:1]};
      if (p_1us && state == SEARCH) begin
        if (fill != 7'd64) fill <= fill + 7'd1;
        wcnt <= wcnt + 10'd1;
      end
      if (p_1us && state == TRAILER && tcnt != 3'd4) begin
        tcnt <= tcnt + 3'd1;
        if (rxbit != exp_b) terr <= 1'b1;
      end
      if (hit) begin
        corr_matches <= match;
        rxCAC        <= (sync_sel == 2'd0);
      end
      if (tdone) trailer_ok <= ~terr;
    end
  end

endmodule

// File: tb/tb_accesscode_corr.sv
// Directed bench for accesscode_corr: pulse events are scoreboarded by cycle,
// held flags are checked directly after each scenario.
`timescale 1ns/1ps
module tb_accesscode_corr;

  logic        clk_6M = 1'b0;
  logic        rst = 1'b1;
  logic        p_1us = 1'b0;
  logic        rxbit = 1'b0;
  logic        corr_en = 1'b0;
  logic [1:0]  sync_sel = 2'd0;
  logic [63:0] w_cac  = 64'h1234_5678_9ABC_DEF0;
  logic [63:0] w_dac  = 64'h0F1E_2D3C_4B5A_6978;
  logic [63:0] w_giac = 64'hC6A5_1B3E_9D70_2F84;
  logic [63:0] w_diac = 64'h5A5A_F00D_CAFE_1234;
  logic [6:0]  th = 7'd64;
  logic [9:0]  win = 10'd0;
  logic        rx_trailer_st_p, rxCAC, sync_miss_p;
  logic        trailer_done_p, trailer_ok;
  logic [6:0]  corr_matches;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  ncmp = 0;
  int  nerr = 0;

  accesscode_corr dut (
    .clk_6M(clk_6M),
    .rst(rst),
    .p_1us(p_1us),
    .rxbit(rxbit),
    .corr_en(corr_en),
    .sync_sel(sync_sel),
    .regi_syncword_CAC(w_cac),
    .regi_syncword_DAC(w_dac),
    .regi_syncword_GIAC(w_giac),
    .regi_syncword_DIAC(w_diac),
    .regi_corr_th(th),
    .regi_search_win(win),
    .rx_trailer_st_p(rx_trailer_st_p),
    .rxCAC(rxCAC),
    .sync_miss_p(sync_miss_p),
    .trailer_done_p(trailer_done_p),
    .trailer_ok(trailer_ok),
    .corr_matches(corr_matches)
  );

  always #5 clk_6M = ~clk_6M;
  always @(posedge clk_6M) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs,
                     input longint expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // kind: 0 = trailer start, 1 = sync miss, 2 = trailer done
  task automatic got_pulse(input int kind);
    ev_t e;
    chk("pulse_was_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk_6M) begin
    if (!rst) begin
      if (rx_trailer_st_p) got_pulse(0);
      if (sync_miss_p)     got_pulse(1);
      if (trailer_done_p)  got_pulse(2);
    end
  end

  task automatic send_bit(input logic b, input int kind);
    @(posedge clk_6M);
    #1;
    p_1us = 1'b1;
    rxbit = b;
    if (kind >= 0) exp_q.push_back('{kind, cyc + 2});
    @(posedge clk_6M);
    #1;
    p_1us = 1'b0;
    repeat (5) @(posedge clk_6M);
  endtask

  task automatic send_word(input logic [63:0] w, input int n,
                           input int last_kind);
    for (int i = 0; i < n; i++)
      send_bit(w[i], (i == n - 1) ? last_kind : -1);
  endtask

  task automatic restart();
    @(posedge clk_6M);
    #1 corr_en = 1'b0;
    @(posedge clk_6M);
    #1 corr_en = 1'b1;
    repeat (2) @(posedge clk_6M);
    #1;
  endtask

  task automatic stop();
    @(posedge clk_6M);
    #1 corr_en = 1'b0;
    repeat (3) @(posedge clk_6M);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    repeat (3) @(posedge clk_6M);
    #1 rst = 1'b0;
    @(posedge clk_6M);
    #1;
    chk("rst_trailer_st", rx_trailer_st_p, 0);
    chk("rst_rxcac", rxCAC, 0);
    chk("rst_miss", sync_miss_p, 0);
    chk("rst_done", trailer_done_p, 0);
    chk("rst_ok", trailer_ok, 0);
    chk("rst_matches", corr_matches, 0);

    // exact CAC match, good trailer 1010
    sync_sel = 2'd0; th = 7'd64; win = 10'd0;
    restart();
    send_bit(1'b1, -1); send_bit(1'b1, -1);
    send_bit(1'b0, -1); send_bit(1'b0, -1);
    send_word(w_cac, 64, 0);
    chk("cac_rxcac", rxCAC, 1);
    chk("cac_matches", corr_matches, 64);
    send_bit(1'b1, -1); send_bit(1'b0, -1);
    send_bit(1'b1, -1); send_bit(1'b0, 2);
    chk("cac_trailer_ok", trailer_ok, 1);
    send_bit(1'b1, -1); send_bit(1'b0, -1);
    stop();
    chk("cac_ok_held", trailer_ok, 1);
    chk("cac_rxcac_held", rxCAC, 1);

    // DAC with 3 flipped bits, th=61 hits
    w = w_dac ^ ((64'd1 << 5) | (64'd1 << 30) | (64'd1 << 50));
    sync_sel = 2'd1; th = 7'd61;
    restart();
    chk("start_clr_ok", trailer_ok, 0);
    chk("start_clr_rxcac", rxCAC, 0);
    chk("start_clr_matches", corr_matches, 0);
    send_bit(1'b0, -1); send_bit(1'b1, -1);
    send_bit(1'b1, -1); send_bit(1'b0, -1);
    send_word(w, 64, 0);
    chk("dac61_matches", corr_matches, 61);
    chk("dac61_rxcac", rxCAC, 0);
    stop();
    chk("dac61_held", corr_matches, 61);

    // same stream, th=62 never hits
    th = 7'd62;
    restart();
    send_bit(1'b0, -1); send_bit(1'b1, -1);
    send_bit(1'b1, -1); send_bit(1'b0, -1);
    send_word(w, 64, -1);
    repeat (4) send_bit(1'b0, -1);
    chk("dac62_matches", corr_matches, 0);
    stop();

    // timeout after 100 random strobes; DONE ignores later bits
    sync_sel = 2'd2; th = 7'd64; win = 10'd100;
    restart();
    for (int i = 1; i <= 100; i++)
      send_bit(1'($urandom_range(0, 1)), (i == 100) ? 1 : -1);
    repeat (10) send_bit(1'($urandom_range(0, 1)), -1);
    chk("miss_matches", corr_matches, 0);
    chk("miss_pending", exp_q.size(), 0);
    stop();

    // GIAC MSB=1 expects 0101; send 0111
    win = 10'd0;
    restart();
    send_word(w_giac, 64, 0);
    chk("giac_matches", corr_matches, 64);
    chk("giac_rxcac", rxCAC, 0);
    send_bit(1'b0, -1); send_bit(1'b1, -1);
    send_bit(1'b1, -1); send_bit(1'b1, 2);
    chk("giac_bad_ok", trailer_ok, 0);
    stop();
    restart();
    send_word(w_giac, 64, 0);
    send_bit(1'b0, -1); send_bit(1'b1, -1);
    send_bit(1'b0, -1); send_bit(1'b1, 2);
    chk("giac_good_ok", trailer_ok, 1);
    stop();

    // abort after 40 bits, restart; hit coincides with window expiry
    sync_sel = 2'd3; win = 10'd64;
    restart();
    chk("abort_clr_ok", trailer_ok, 0);
    send_word(w_diac, 40, -1);
    stop();
    restart();
    send_word(w_diac, 64, 0);
    chk("diac_matches", corr_matches, 64);

    // reset during the trailer
    send_bit(1'b1, -1); send_bit(1'b0, -1);
    @(posedge clk_6M);
    #1 rst = 1'b1; corr_en = 1'b0;
    @(posedge clk_6M);
    #1;
    chk("mid_rst_matches", corr_matches, 0);
    chk("mid_rst_ok", trailer_ok, 0);
    chk("mid_rst_rxcac", rxCAC, 0);
    chk("mid_rst_done", trailer_done_p, 0);
    rst = 1'b0;
    send_bit(1'b1, -1); send_bit(1'b0, -1);
    chk("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
